vec_execute_unit: RTL



---
 rtl/vec_execute_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vec_execute_unit.sv
// vec_execute_unit: execute stage of the vector CPU pipeline.
//   Single-cycle ops (VADD/VSUB/VADDI/VSHL/ADD/SUB/ADDI) register their result
//   on the accepting edge. Lane-serial ops (VMUL/VDOT) use one shared 8x8
//   multiplier for one lane per clock over 8 clocks. o_stall freezes upstream
//   while they run.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_en               stage advance; low freezes all state and outputs
//   i_opcode           5-bit operation code
//   i_reg1/2_data      32-bit scalar operands
//   i_immediate        8-bit immediate, zero-extended
//   i_vec1/2_data      64-bit vectors, lane i = bits [8i+7:8i]
//   i_wb_register      destination register index
//   o_stall            high while a lane-serial op is in progress
//   o_res_*            registered results, destination index and write enables

// Per-lane single-cycle ALU. Select codes: 0 add, 1 sub, 2 add imm, 3 shl imm.
module vec_lane_alu (
    input  logic [1:0] i_sel,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_imm,
    output logic [7:0] o_res
);
    always_comb begin
        o_res = 8'h00;
        case (i_sel)
            2'd0: o_res = i_a + i_b;
            2'd1: o_res = i_a - i_b;
            2'd2: o_res = i_a + i_imm;
            2'd3: o_res = i_a << i_imm[2:0];
            default: o_res = 8'h00;
        endcase
    end
endmodule

module vec_execute_unit #(
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [4:0]            i_opcode,
    input  logic [31:0]           i_reg1_data,
    input  logic [31:0]           i_reg2_data,
    input  logic [7:0]            i_immediate,
    input  logic [LANES*8-1:0]    i_vec1_data,
    input  logic [LANES*8-1:0]    i_vec2_data,
    input  logic [2:0]            i_wb_register,
    output logic                  o_stall,
    output logic [31:0]           o_res_scalar,
    output logic [LANES*8-1:0]    o_res_vec,
    output logic [2:0]            o_res_wb_register,
    output logic                  o_res_scalar_valid,
    output logic                  o_res_vec_valid
);
    localparam logic [4:0] OP_VADD  = 5'b00000;
    localparam logic [4:0] OP_VSUB  = 5'b00001;
    localparam logic [4:0] OP_VADDI = 5'b00010;
    localparam logic [4:0] OP_VMUL  = 5'b00011;
    localparam logic [4:0] OP_VSHL  = 5'b00100;
    localparam logic [4:0] OP_VDOT  = 5'b00101;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_SUB   = 5'b01001;
    localparam logic [4:0] OP_ADDI  = 5'b01010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               r_state, w_state_next;
    logic [3:0]           r_cnt;
    logic [LANES*8-1:0]   r_v1, r_v2, r_pvec;
    logic [2:0]           r_wb;
    logic [4:0]           r_op;
    logic [31:0]          r_acc;
    logic [31:0]          r_res_scalar;
    logic [LANES*8-1:0]   r_res_vec;
    logic [2:0]           r_res_wb;
    logic                 r_sval, r_vval;

    logic                 w_serial;
    logic [1:0]           w_sel;
    logic [LANES*8-1:0]   w_lane_vec;
    logic [7:0]           w_la, w_lb;
    logic [15:0]          w_prod;
    logic                 w_last;

    assign w_serial = (i_opcode == OP_VMUL) || (i_opcode == OP_VDOT);
    assign w_last   = (r_cnt == 4'd7);

    always_comb begin
        w_sel = 2'd0;
        case (i_opcode)
            OP_VSUB:  w_sel = 2'd1;
            OP_VADDI: w_sel = 2'd2;
            OP_VSHL:  w_sel = 2'd3;
            default:  w_sel = 2'd0;
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vec_lane_alu u_lane (
            .i_sel (w_sel),
            .i_a   (i_vec1_data[8*g +: 8]),
            .i_b   (i_vec2_data[8*g +: 8]),
            .i_imm (i_immediate),
            .o_res (w_lane_vec[8*g +: 8])
        );
    end

    // Shared multiplier, fed from the captured operands by the lane counter.
    assign w_la   = r_v1[{r_cnt[2:0], 3'b000} +: 8];
    assign w_lb   = r_v2[{r_cnt[2:0], 3'b000} +: 8];
    assign w_prod = {8'h00, w_la} * {8'h00, w_lb};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_en && w_serial) w_state_next = BUSY;
            BUSY: if (i_en && w_last)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_acc        <= 32'd0;
            r_res_scalar <= 32'd0;
            r_res_vec    <= '0;
            r_res_wb     <= 3'd0;
            r_sval       <= 1'b0;
            r_vval       <= 1'b0;
        end else if (i_en) begin
            if (r_state == IDLE) begin
                // Every accepted instruction clears the valids unless it writes.
                r_sval <= 1'b0;
                r_vval <= 1'b0;
                case (i_opcode)
                    OP_VADD, OP_VSUB, OP_VADDI, OP_VSHL: begin
                        r_res_vec <= w_lane_vec;
                        r_res_wb  <= i_wb_register;
                        r_vval    <= 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        if (i_opcode == OP_ADD)
                            r_res_scalar <= i_reg1_data + i_reg2_data;
                        else if (i_opcode == OP_SUB)
                            r_res_scalar <= i_reg1_data - i_reg2_data;
                        else
                            r_res_scalar <= i_reg1_data + {24'd0, i_immediate};
                        r_res_wb <= i_wb_register;
                        r_sval   <= 1'b1;
                    end
                    OP_VMUL, OP_VDOT: begin
                        r_v1  <= i_vec1_data;
                        r_v2  <= i_vec2_data;
                        r_wb  <= i_wb_register;
                        r_op  <= i_opcode;
                        r_cnt <= 4'd0;
                        r_acc <= 32'd0;
                    end
                    default: ;
                endcase
            end else begin
                r_cnt <= r_cnt + 4'd1;
                r_pvec[{r_cnt[2:0], 3'b000} +: 8] <= w_prod[7:0];
                r_acc <= r_acc + {16'd0, w_prod};
                if (w_last) begin
                    // Final lane bypasses r_pvec/r_acc so the result lands this edge.
                    r_res_wb <= r_wb;
                    if (r_op == OP_VMUL) begin
                        r_res_vec <= {w_prod[7:0], r_pvec[LANES*8-9:0]};
                        r_vval    <= 1'b1;
                    end else begin
                        r_res_scalar <= r_acc + {16'd0, w_prod};
                        r_sval       <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_stall            = (r_state == BUSY);
    assign o_res_scalar       = r_res_scalar;
    assign o_res_vec          = r_res_vec;
    assign o_res_wb_register  = r_res_wb;
    assign o_res_scalar_valid = r_sval;
    assign o_res_vec_valid    = r_vval;
endmodule
